dmem_lat: RTL and testbench
===========================

Name: dmem_lat

Overview:
Parametrised successor to the single-cycle data memory, for the multicycle and cached cores. The memory is word-organised and adds three things the single-cycle memory lacks:
- a req/ready request handshake with a configurable wait-state latency;
- per-byte write enables;
- error reporting for misaligned and out-of-range accesses.
It sits between the core's load/store unit and backing storage, and holds one transaction in flight.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width; must be a multiple of 8.
- DEPTH, 64, number of words; must be a power of 2.
- LATENCY, 2, wait-state cycles between accept and response; 0 is legal.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  1  request valid
- we  in  1  1 = write, 0 = read; sampled on accept
- addr  in  ADDR_W  byte address
- wdata  in  DATA_W  write data
- be  in  DATA_W/8  byte enables for writes; ignored for reads
- ready  out  1  request can be accepted this cycle
- done  out  1  one-cycle response strobe, for both reads and writes
- rvalid  out  1  read data valid; asserted together with done on reads
- rdata  out  DATA_W  read data
- err  out  1  access error; qualified by done

Behaviour:
Derived constants:
- OFF = $clog2(DATA_W/8)
- IW = $clog2(DEPTH)
- index = addr[OFF+IW-1:OFF]

State machine: IDLE, WAIT, RESP.
- Accept occurs when req & ready. On accept, register we, addr, wdata, be and the error flags.
- ready = (state == IDLE) || (state == RESP). This allows back-to-back acceptance in the response cycle. ready is 0 in WAIT.
- Accept with LATENCY > 0: go to WAIT and load the counter with LATENCY-1. WAIT decrements the counter and moves to RESP when it reaches 0.
- Accept with LATENCY == 0: go directly to RESP.
- Timing: an accept at cycle T gives done=1 in cycle T+LATENCY+1, for exactly one cycle.
- RESP with no new accept: go to IDLE. RESP with an accept: restart the sequence exactly as from IDLE.
- req while in WAIT is ignored. The requester must hold req until it sees ready.

Error conditions, evaluated on the captured address:
- misaligned: addr[OFF-1:0] != 0;
- out of range: any bit of addr[ADDR_W-1:OFF+IW] is 1.
- err is asserted with done. An errored write leaves memory unmodified. An errored read returns rdata = 0 with rvalid = 1.

Writes:
- Commit at the rising edge that ends the RESP cycle.
- Byte lane i is written only if be[i] = 1; be == 0 writes nothing but still produces done.
- Simulation prints "address %h now has data %h" with the merged word on each commit.

Reads:
- rdata is registered into the RESP cycle from the array content at the end of the WAIT phase.
- A read issued back-to-back after a write to the same address returns the new data, because the write commits before the read's array sample.
- rdata holds its value until the next read response.

Reset:
- Reset is asynchronous: state goes to IDLE and the counter to 0.
- Reset values: done=0, rvalid=0, err=0, rdata=0. ready=1 once reset is deasserted.
- Reset mid-transaction drops the transaction: no done, and no write commit.
- Array contents are not reset.

Decomposition:
- Package dmem_pkg holds the state_t enum (IDLE, WAIT, RESP) and the localparam helper functions off_w(DATA_W) and idx_w(DEPTH).
- Sub-module dmem_array holds the storage: DEPTH x DATA_W, combinational read port, synchronous write port with per-byte enables.
- dmem_lat contains the FSM, latency counter, capture registers and error checks.

Test Plan:
All scenarios use DEPTH=64, DATA_W=32, LATENCY=2 unless stated.
1. Write 0x54 / 0x00000007 / be 4'hF with accept at cycle 0 -> done=1 and err=0 at cycle 3, ready=0 in cycles 1-2. Then read 0x54 -> rvalid=1 and rdata=0x00000007 three cycles after its accept.
2. Write 0x10 = 0xAABBCCDD, then write 0x10 = 0x11223344 with be 4'b0101, then read 0x10 -> rdata=0xAA22CC44.
3. Misaligned and out-of-range accesses:
   - write to 0x13 -> done+err at +3; a following read of 0x10 is unchanged;
   - read 0x100 -> done, rvalid, err=1, rdata=0.
4. req held high for reads 0x04 then 0x08 -> the second is accepted in the first's RESP cycle; done at cycles 3 and 6, each with the correct data.
5. Write to 0x20 accepted at cycle 0, reset pulsed in cycle 1 -> no done; a read of 0x20 returns its previous value; ready=1 after reset is released.
6. LATENCY=0 instance with req held high for 4 reads -> done every cycle from cycle 1 to cycle 4, ready constantly 1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the latency-configurable data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Width of the byte-offset field inside a word address.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Width of the word index into the storage array.
    function automatic int idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: DEPTH x DATA_W, combinational read, synchronous byte-enabled write.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    localparam int IW    = idx_w(DEPTH),
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [NB-1:0]     wr_be,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IW-1:0]     rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; clearing it would turn the array into flops with a reset tree.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_en && wr_be[b]) begin
                mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_lat.sv
// Data memory with req/ready handshake, configurable wait states, byte enables and error reporting.
module dmem_lat
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic                ready,
    output logic                done,
    output logic                rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                err
);

    localparam int OFF   = off_w(DATA_W);
    localparam int IW    = idx_w(DEPTH);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              accept;
    logic              commit;
    logic              load_rd;
    logic              s_we;
    logic              s_err;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] fwd_word;

    // Any set bit below the word offset or above the index field is an error.
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        logic e;
        e = 1'b0;
        for (int i = 0; i < ADDR_W; i++) begin
            if ((i < OFF || i >= OFF + IW) && a[i]) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [NB-1:0]     en);
        logic [DATA_W-1:0] m;
        m = old_w;
        for (int b = 0; b < NB; b++) begin
            if (en[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return m;
    endfunction

    assign ready  = (state_q == IDLE) || (state_q == RESP);
    assign done   = (state_q == RESP);
    assign rvalid = done && !we_q;
    assign err    = done && err_q;
    assign rdata  = rdata_q;

    assign accept = req && ready;
    assign commit = (state_q == RESP) && we_q && !err_q;

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    we_d    = we;
                    idx_d   = addr[OFF +: IW];
                    wdata_d = wdata;
                    be_d    = be;
                    err_d   = addr_err(addr);
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // The transaction entering RESP comes from the capture registers after a wait,
        // or straight from the request pins when there are no wait states.
        if (state_q == WAIT) begin
            s_we   = we_q;
            s_err  = err_q;
            rd_idx = idx_q;
        end else begin
            s_we   = we;
            s_err  = addr_err(addr);
            rd_idx = addr[OFF +: IW];
        end
        load_rd = ((state_q == WAIT) && (cnt_q == '0)) || ((LATENCY == 0) && accept);

        // A write committing on this edge must be visible to a read sampled on the same edge.
        fwd_word = (commit && (rd_idx == idx_q)) ? merge_bytes(arr_rdata, wdata_q, be_q) : arr_rdata;

        if (load_rd && !s_we) begin
            rdata_d = s_err ? '0 : fwd_word;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .wr_en   (commit),
        .wr_be   (be_q),
        .wr_idx  (idx_q),
        .wr_data (wdata_q),
        .rd_idx  (rd_idx),
        .rd_data (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_lat.sv
// Directed bench for dmem_lat: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dmem_lat;

    logic        clk = 1'b0;
    logic        reset;

    logic        req, we, ready, done, rvalid, err;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    logic        z_req, z_we, z_ready, z_done, z_rvalid, z_err;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic [3:0]  z_be;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] vals [4] = '{32'h0BAD_F00D, 32'h1357_9BDF, 32'h2468_ACE0, 32'hFEED_BEEF};

    always #5 clk = ~clk;

    dmem_lat #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .done(done), .rvalid(rvalid), .rdata(rdata), .err(err)
    );

    dmem_lat #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req(z_req), .we(z_we), .addr(z_addr), .wdata(z_wdata), .be(z_be),
        .ready(z_ready), .done(z_done), .rvalid(z_rvalid), .rdata(z_rdata), .err(z_err)
    );

    // Commit trace with the merged word as stored in the array.
    always @(posedge clk) begin
        if (dut.commit) begin
            automatic logic [5:0] ci = dut.idx_q;
            #1 $display("address %h now has data %h", {ci, 2'b00}, dut.u_array.mem[ci]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the LATENCY=2 port; lat counts cycles from accept to done.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rd, output logic e, output logic rv);
        bit got;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
            else tick();
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
        tick();
        req = 1'b0;
        got = 1'b0; lat = 0; rd = 'x; e = 1'bx; rv = 1'bx;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1; lat = i; rd = rdata; e = err; rv = rvalid;
            end else begin
                tick();
            end
        end
        if (!got) check("done_timeout", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e, rv;

        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_be = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_done",   done,   32'd0);
        check("rst_rvalid", rvalid, 32'd0);
        check("rst_err",    err,    32'd0);
        check("rst_rdata",  rdata,  32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready",  ready,   32'd1);
        check("rst_ready0", z_ready, 32'd1);
        tick();

        // 1: write 0x54, timing of ready/done, then read it back
        req = 1'b1; we = 1'b1; addr = 32'h54; wdata = 32'h7; be = 4'hF;
        @(negedge clk); check("s1_ready_c0", ready, 32'd1);
        tick(); req = 1'b0;
        @(negedge clk); check("s1_ready_c1", ready, 32'd0); check("s1_done_c1", done, 32'd0);
        tick();
        @(negedge clk); check("s1_ready_c2", ready, 32'd0); check("s1_done_c2", done, 32'd0);
        tick();
        @(negedge clk); check("s1_done_c3", done, 32'd1); check("s1_err_c3", err, 32'd0);
        check("s1_rvalid_c3", rvalid, 32'd0);
        tick();
        txn(1'b0, 32'h54, 32'h0, 4'h0, lat, rd, e, rv);
        check("s1_rd_lat", lat, 32'd3); check("s1_rd_rvalid", rv, 32'd1);
        check("s1_rd_data", rd, 32'h7); check("s1_rd_err", e, 32'd0);

        // 2: byte-enable merge
        txn(1'b1, 32'h10, 32'hAABBCCDD, 4'hF, lat, rd, e, rv);
        txn(1'b1, 32'h10, 32'h11223344, 4'b0101, lat, rd, e, rv);
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rv);
        check("s2_merge", rd, 32'hAA22CC44);

        // 3: misaligned / out-of-range / empty byte enable
        txn(1'b1, 32'h13, 32'hDEADBEEF, 4'hF, lat, rd, e, rv);
        check("s3_mis_lat", lat, 32'd3); check("s3_mis_err", e, 32'd1);
        txn(1'b1, 32'h110, 32'hDEADBEEF, 4'hF, lat, rd, e, rv);
        check("s3_oorw_err", e, 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rv);
        check("s3_unchanged", rd, 32'hAA22CC44); check("s3_ok_err", e, 32'd0);
        txn(1'b1, 32'h10, 32'h0, 4'h0, lat, rd, e, rv);
        check("s3_be0_lat", lat, 32'd3); check("s3_rdata_hold", rd, 32'hAA22CC44);
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e, rv);
        check("s3_be0_unchanged", rd, 32'hAA22CC44);
        txn(1'b0, 32'h100, 32'h0, 4'h0, lat, rd, e, rv);
        check("s3_oor_err", e, 32'd1); check("s3_oor_rvalid", rv, 32'd1); check("s3_oor_rdata", rd, 32'h0);

        // 4: back-to-back reads with req held
        txn(1'b1, 32'h04, 32'h12345678, 4'hF, lat, rd, e, rv);
        txn(1'b1, 32'h08, 32'h9ABCDEF0, 4'hF, lat, rd, e, rv);
        req = 1'b1; we = 1'b0; addr = 32'h04;
        @(negedge clk); check("s4_ready_c0", ready, 32'd1);
        tick(); addr = 32'h08;
        @(negedge clk); check("s4_ready_c1", ready, 32'd0);
        tick();
        @(negedge clk); check("s4_done_c2", done, 32'd0);
        tick();
        @(negedge clk); check("s4_done_c3", done, 32'd1); check("s4_data_c3", rdata, 32'h12345678);
        check("s4_ready_c3", ready, 32'd1);
        tick(); req = 1'b0;
        @(negedge clk); check("s4_done_c4", done, 32'd0);
        tick();
        @(negedge clk); check("s4_done_c5", done, 32'd0);
        tick();
        @(negedge clk); check("s4_done_c6", done, 32'd1); check("s4_data_c6", rdata, 32'h9ABCDEF0);
        check("s4_rvalid_c6", rvalid, 32'd1);
        tick();

        // 4b: write then read of the same word back-to-back
        req = 1'b1; we = 1'b1; addr = 32'h0C; wdata = 32'hCAFEF00D; be = 4'hF;
        tick(); we = 1'b0;
        tick(); tick();
        @(negedge clk); check("s4b_wr_done", done, 32'd1); check("s4b_wr_rvalid", rvalid, 32'd0);
        tick(); req = 1'b0;
        tick(); tick();
        @(negedge clk); check("s4b_rd_done", done, 32'd1); check("s4b_rd_data", rdata, 32'hCAFEF00D);
        tick();

        // 5: reset mid-transaction drops the write
        txn(1'b1, 32'h20, 32'h55AA55AA, 4'hF, lat, rd, e, rv);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; be = 4'hF;
        tick(); req = 1'b0; reset = 1'b1;
        @(negedge clk); check("s5_done_rst", done, 32'd0);
        tick(); reset = 1'b0;
        @(negedge clk); check("s5_ready", ready, 32'd1); check("s5_done_c2", done, 32'd0);
        check("s5_rdata_reset", rdata, 32'd0);
        tick();
        @(negedge clk); check("s5_done_c3", done, 32'd0);
        tick();
        @(negedge clk); check("s5_done_c4", done, 32'd0);
        tick();
        txn(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, e, rv);
        check("s5_old_data", rd, 32'h55AA55AA);

        // 6: LATENCY=0, four writes then four reads with req held
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                z_req   = 1'b1;
                z_we    = (k < 4);
                z_addr  = (k < 4) ? 32'(k * 4) : 32'((7 - k) * 4);
                z_wdata = vals[(k < 4) ? k : 0];
                z_be    = 4'hF;
            end else begin
                z_req = 1'b0;
            end
            @(negedge clk);
            if (k < 8) check($sformatf("s6_ready_c%0d", k), z_ready, 32'd1);
            check($sformatf("s6_done_c%0d", k), z_done, (k == 0) ? 32'd0 : 32'd1);
            if (k >= 5) begin
                check($sformatf("s6_rvalid_c%0d", k), z_rvalid, 32'd1);
                check($sformatf("s6_rdata_c%0d", k), z_rdata, vals[8 - k]);
            end else if (k >= 1) begin
                check($sformatf("s6_wr_rvalid_c%0d", k), z_rvalid, 32'd0);
            end
            tick();
        end
        @(negedge clk); check("s6_done_end", z_done, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
